// File: rtl/add4_accum_seq_if.sv
// Input beat stream and result stream of the neuron accumulator.
// The master side feeds beats and consumes results; the slave side is the accumulator.
interface add4_accum_seq_if #(
    parameter int WIDTH_IN  = 8,
    parameter int ACC_WIDTH = 16
);
    logic                        in_valid;
    logic                        in_ready;
    logic signed [WIDTH_IN-1:0]  in_data0;
    logic signed [WIDTH_IN-1:0]  in_data1;
    logic signed [WIDTH_IN-1:0]  in_data2;
    logic signed [WIDTH_IN-1:0]  in_data3;
    logic                        out_valid;
    logic                        out_ready;
    logic signed [ACC_WIDTH-1:0] out_acc;
    logic                        out_bit;

    modport master (
        output in_valid, in_data0, in_data1, in_data2, in_data3, out_ready,
        input  in_ready, out_valid, out_acc, out_bit
    );

    modport slave (
        input  in_valid, in_data0, in_data1, in_data2, in_data3, out_ready,
        output in_ready, out_valid, out_acc, out_bit
    );
endinterface

// File: rtl/add4_accum_seq.sv
// Drives one registered add4 tree beat by beat and accumulates its sums (saturating)
// into a BNN neuron pre-activation plus a thresholded activation bit.
module add4_accum_seq #(
    parameter int WIDTH_IN  = 8,
    parameter int ACC_WIDTH = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [7:0]                  cfg_beats,
    input  logic signed [ACC_WIDTH-1:0] cfg_threshold,
    add4_accum_seq_if.slave             bus,
    output logic signed [WIDTH_IN-1:0]  add_in0,
    output logic signed [WIDTH_IN-1:0]  add_in1,
    output logic signed [WIDTH_IN-1:0]  add_in2,
    output logic signed [WIDTH_IN-1:0]  add_in3,
    input  logic signed [WIDTH_IN+1:0]  add_sum
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DRAIN = 2'd2,
        OUT   = 2'd3
    } state_t;

    state_t                      state;
    state_t                      state_next;
    logic [7:0]                  beats;
    logic [7:0]                  count;
    logic signed [ACC_WIDTH-1:0] threshold;
    logic signed [ACC_WIDTH-1:0] acc;
    logic signed [ACC_WIDTH-1:0] acc_next;
    logic signed [ACC_WIDTH:0]   acc_wide;
    logic signed [ACC_WIDTH-1:0] out_acc_q;
    logic                        out_bit_q;
    logic                        sum_valid;
    logic                        hs;
    logic                        out_hs;
    logic                        last_beat;
    logic                        start;

    function automatic logic signed [ACC_WIDTH-1:0] sat(input logic signed [ACC_WIDTH:0] v);
        logic signed [ACC_WIDTH-1:0] r;
        if (v[ACC_WIDTH] != v[ACC_WIDTH-1])
            r = v[ACC_WIDTH] ? {1'b1, {(ACC_WIDTH-1){1'b0}}} : {1'b0, {(ACC_WIDTH-1){1'b1}}};
        else
            r = v[ACC_WIDTH-1:0];
        return r;
    endfunction

    assign hs        = bus.in_valid && (state == ACCUM);
    assign out_hs    = bus.out_ready && (state == OUT);
    assign last_beat = hs && ((count + 8'd1) == beats);
    // A neuron starts either from IDLE or straight out of a consumed result.
    assign start     = (state == IDLE) || out_hs;

    assign add_in0 = hs ? bus.in_data0 : '0;
    assign add_in1 = hs ? bus.in_data1 : '0;
    assign add_in2 = hs ? bus.in_data2 : '0;
    assign add_in3 = hs ? bus.in_data3 : '0;

    assign acc_wide = $signed({acc[ACC_WIDTH-1], acc})
                    + $signed({{(ACC_WIDTH-WIDTH_IN-1){add_sum[WIDTH_IN+1]}}, add_sum});
    assign acc_next = sum_valid ? sat(acc_wide) : acc;

    assign bus.out_acc = out_acc_q;
    assign bus.out_bit = out_bit_q;

    always_ff @(posedge clk) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next    = state;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        unique case (state)
            IDLE:  state_next = ACCUM;
            ACCUM: begin
                bus.in_ready = 1'b1;
                if (last_beat)
                    state_next = DRAIN;
            end
            DRAIN: state_next = OUT;
            OUT: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready)
                    state_next = ACCUM;
            end
            default: state_next = IDLE;
        endcase
    end

    // Stage boundary: adder output (1-cycle latency) folds into acc one cycle after its beat.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            beats     <= 8'd1;
            threshold <= '0;
            count     <= '0;
            acc       <= '0;
            sum_valid <= 1'b0;
            out_acc_q <= '0;
            out_bit_q <= 1'b0;
        end else begin
            sum_valid <= hs;
            if (start) begin
                beats     <= (cfg_beats == 8'd0) ? 8'd1 : cfg_beats;
                threshold <= cfg_threshold;
                count     <= '0;
                acc       <= '0;
            end else begin
                if (hs)
                    count <= count + 8'd1;
                acc <= acc_next;
            end
            if (state == DRAIN) begin
                out_acc_q <= acc_next;
                out_bit_q <= (acc_next >= threshold);
            end
        end
    end

endmodule

// File: tb/tb_add4_accum_seq.sv
// Bench for add4_accum_seq: a 16-bit and a 10-bit accumulator run in lockstep on the
// same stimulus, each with its own registered add4 model, checked against a beat-level model.
module tb_add4_accum_seq;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [7:0]        cfg_beats;
    logic signed [15:0] cfg_thr;
    logic signed [9:0]  thr10;
    logic              in_valid;
    logic              out_ready;
    logic signed [7:0] d0, d1, d2, d3;

    logic signed [7:0] a16_0, a16_1, a16_2, a16_3;
    logic signed [7:0] a10_0, a10_1, a10_2, a10_3;
    logic signed [9:0] s16 = '0;
    logic signed [9:0] s10 = '0;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int hs_cyc = 0;
    int res_cyc = 0;

    // beat-level model state
    int ph = 0;  // 0 idle, 1 accepting beats, 2 drain, 3 result offered
    int m_beats, m_cnt, m_thr16, m_thr10, m_acc16, m_acc10;
    int e_acc16 = 0, e_acc10 = 0;
    int e_bit16 = 0, e_bit10 = 0;

    always #5 clk = ~clk;

    assign thr10 = cfg_thr[9:0];

    add4_accum_seq_if #(.WIDTH_IN(8), .ACC_WIDTH(16)) bus16 ();
    add4_accum_seq_if #(.WIDTH_IN(8), .ACC_WIDTH(10)) bus10 ();

    assign bus16.in_valid  = in_valid;
    assign bus16.in_data0  = d0;
    assign bus16.in_data1  = d1;
    assign bus16.in_data2  = d2;
    assign bus16.in_data3  = d3;
    assign bus16.out_ready = out_ready;
    assign bus10.in_valid  = in_valid;
    assign bus10.in_data0  = d0;
    assign bus10.in_data1  = d1;
    assign bus10.in_data2  = d2;
    assign bus10.in_data3  = d3;
    assign bus10.out_ready = out_ready;

    add4_accum_seq #(.WIDTH_IN(8), .ACC_WIDTH(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .cfg_beats(cfg_beats), .cfg_threshold(cfg_thr),
        .bus(bus16.slave),
        .add_in0(a16_0), .add_in1(a16_1), .add_in2(a16_2), .add_in3(a16_3),
        .add_sum(s16)
    );

    add4_accum_seq #(.WIDTH_IN(8), .ACC_WIDTH(10)) dut10 (
        .clk(clk), .rst_n(rst_n), .cfg_beats(cfg_beats), .cfg_threshold(thr10),
        .bus(bus10.slave),
        .add_in0(a10_0), .add_in1(a10_1), .add_in2(a10_2), .add_in3(a10_3),
        .add_sum(s10)
    );

    // external add4 trees, registered
    always @(posedge clk) begin
        s16 <= 10'(a16_0) + 10'(a16_1) + 10'(a16_2) + 10'(a16_3);
        s10 <= 10'(a10_0) + 10'(a10_1) + 10'(a10_2) + 10'(a10_3);
    end

    function automatic int clamp(input int v, input int w);
        int hi = (1 << (w - 1)) - 1;
        int lo = -(1 << (w - 1));
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

    task automatic chk(input string nm, input logic signed [31:0] act, input logic signed [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic fail_timeout(input string nm);
        checks++;
        errors++;
        $display("FAIL %s: timed out waiting, expected event within budget", nm);
    endtask

    task automatic model_start();
        m_beats = (cfg_beats == 8'd0) ? 1 : int'(cfg_beats);
        m_thr16 = int'(cfg_thr);
        m_thr10 = int'(thr10);
        m_cnt   = 0;
        m_acc16 = 0;
        m_acc10 = 0;
    endtask

    // model step on each edge, full output comparison half a cycle later
    initial begin
        int s;
        forever begin
            @(posedge clk);
            cyc++;
            if (!rst_n) begin
                ph = 0; m_acc16 = 0; m_acc10 = 0;
                e_acc16 = 0; e_acc10 = 0; e_bit16 = 0; e_bit10 = 0;
            end else begin
                case (ph)
                    0: begin model_start(); ph = 1; end
                    1: if (in_valid) begin
                        s = int'(d0) + int'(d1) + int'(d2) + int'(d3);
                        m_acc16 = clamp(m_acc16 + s, 16);
                        m_acc10 = clamp(m_acc10 + s, 10);
                        m_cnt++;
                        if (m_cnt == m_beats) ph = 2;
                    end
                    2: begin
                        e_acc16 = m_acc16; e_bit16 = (m_acc16 >= m_thr16);
                        e_acc10 = m_acc10; e_bit10 = (m_acc10 >= m_thr10);
                        ph = 3;
                    end
                    default: if (out_ready) begin model_start(); ph = 1; end
                endcase
            end
            @(negedge clk);
            chk("in_ready16",  bus16.in_ready,  ph == 1);
            chk("out_valid16", bus16.out_valid, ph == 3);
            chk("out_acc16",   bus16.out_acc,   e_acc16);
            chk("out_bit16",   bus16.out_bit,   e_bit16);
            chk("in_ready10",  bus10.in_ready,  ph == 1);
            chk("out_valid10", bus10.out_valid, ph == 3);
            chk("out_acc10",   bus10.out_acc,   e_acc10);
            chk("out_bit10",   bus10.out_bit,   e_bit10);
            chk("add_in0", a16_0, (in_valid && ph == 1) ? int'(d0) : 0);
            chk("add_in1", a16_1, (in_valid && ph == 1) ? int'(d1) : 0);
            chk("add_in2", a16_2, (in_valid && ph == 1) ? int'(d2) : 0);
            chk("add_in3", a16_3, (in_valid && ph == 1) ? int'(d3) : 0);
        end
    end

    task automatic beat(input int v0, input int v1, input int v2, input int v3);
        int n = 0;
        bit ok = 0;
        in_valid = 1'b1;
        d0 = 8'(v0); d1 = 8'(v1); d2 = 8'(v2); d3 = 8'(v3);
        while (!ok && n < 60) begin
            @(negedge clk);
            if (bus16.in_ready) ok = 1; else n++;
        end
        if (!ok) fail_timeout("beat_accept");
        hs_cyc = cyc;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        d0 = '0; d1 = '0; d2 = '0; d3 = '0;
    endtask

    task automatic gap(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_cfg(input int b, input int t);
        cfg_beats = 8'(b);
        cfg_thr   = 16'(t);
    endtask

    // Waits for a result; lit=1 also pins it to hand-computed values. hold>0 keeps
    // out_ready low that many extra cycles (caller drops out_ready beforehand).
    task automatic get_result(input string nm, input bit lit, input int e16, input int b16,
                              input int e10, input int b10, input int hold);
        int n = 0;
        bit ok = 0;
        while (!ok && n < 60) begin
            @(negedge clk);
            if (bus16.out_valid) ok = 1; else n++;
        end
        if (!ok) fail_timeout({nm, "_valid"});
        res_cyc = cyc;
        if (lit) begin
            chk({nm, "_acc16"}, bus16.out_acc, e16);
            chk({nm, "_bit16"}, bus16.out_bit, b16);
            chk({nm, "_acc10"}, bus10.out_acc, e10);
            chk({nm, "_bit10"}, bus10.out_bit, b10);
        end
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (lit) chk({nm, "_hold_acc16"}, bus16.out_acc, e16);
            chk({nm, "_hold_ready"}, bus16.in_ready, 0);
            chk({nm, "_hold_valid"}, bus16.out_valid, 1);
        end
        if (hold > 0) begin
            @(posedge clk);
            #1 out_ready = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int nb, eff, hold;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        d0 = '0; d1 = '0; d2 = '0; d3 = '0;
        set_cfg(1, 10);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready",  bus16.in_ready, 0);
        chk("rst_out_valid", bus16.out_valid, 0);
        chk("rst_out_acc",   bus16.out_acc, 0);
        chk("rst_out_bit",   bus16.out_bit, 0);
        chk("rst_add_in0",   a16_0, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("idle_in_ready", bus16.in_ready, 0);
        @(negedge clk);
        chk("first_in_ready", bus16.in_ready, 1);
        @(posedge clk);
        #1;

        // single beat
        beat(1, 2, 3, 4);
        set_cfg(3, 0);
        get_result("single", 1, 10, 1, 10, 1, 0);
        chk("single_latency", res_cyc - hs_cyc, 2);

        // stalls between beats
        beat(1, 1, 1, 1); gap(2);
        beat(2, 2, 2, 2); gap(2);
        beat(-1, -1, -1, -1);
        set_cfg(2, 0);
        get_result("stall", 1, 8, 1, 8, 1, 0);

        // negative sum
        beat(-128, -128, -128, -128);
        set_cfg(9, 100);  // mid-neuron cfg change, must not matter
        beat(-128, -128, -128, -128);
        set_cfg(4, 0);
        get_result("neg", 1, -1024, 0, -512, 0, 0);

        // saturation positive
        for (int i = 0; i < 4; i++) beat(127, 127, 127, 127);
        set_cfg(4, 0);
        get_result("satpos", 1, 2032, 1, 511, 1, 0);

        // saturation negative with backpressure, zero count queued next
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) beat(-128, -128, -128, -128);
        set_cfg(0, 0);
        get_result("satneg", 1, -2048, 0, -512, 0, 5);
        cfg_beats = 8'd7;
        beat(5, 5, 5, 5);
        set_cfg(3, 0);
        get_result("zero_cnt", 1, 20, 1, 20, 1, 0);
        chk("zero_cnt_latency", res_cyc - hs_cyc, 2);

        // reset after 2 of 3 beats
        beat(9, 9, 9, 9);
        beat(9, 9, 9, 9);
        set_cfg(1, 0);
        rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        beat(1, 1, 1, 1);
        set_cfg(3, 0);
        get_result("rst_mid", 1, 4, 1, 4, 1, 0);

        // reset on the edge after the last beat (in-flight sum discarded)
        for (int i = 0; i < 3; i++) beat(9, 9, 9, 9);
        set_cfg(1, 0);
        rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        beat(1, 1, 1, 1);
        nb = $urandom_range(0, 6);
        set_cfg(nb, $urandom_range(0, 800) - 400);
        get_result("rst_drain", 1, 4, 1, 4, 1, 0);

        // randomized neurons, checked by the model every cycle
        for (int n = 0; n < 30; n++) begin
            eff = (nb == 0) ? 1 : nb;
            for (int b = 0; b < eff; b++) begin
                gap($urandom_range(0, 2));
                beat($urandom_range(0, 255), $urandom_range(0, 255),
                     $urandom_range(0, 255), $urandom_range(0, 255));
            end
            hold = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 3) : 0;
            if (hold > 0) out_ready = 1'b0;
            nb = $urandom_range(0, 6);
            set_cfg(nb, $urandom_range(0, 800) - 400);
            get_result("rand", 0, 0, 0, 0, 0, hold);
        end

        gap(3);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
